// File: rtl/ws2812_pkg.sv
// Shared WS2812 line timing at 50 MHz. The transmitter and receiver both take their constants from here.
package ws2812_pkg;

    localparam int CLK_HZ     = 50_000_000;
    localparam int T0H        = 21;
    localparam int T1H        = 41;
    localparam int TOTAL      = 63;
    localparam int RESET_TIME = 2500;

    localparam int BIT_THRESH = 31;
    localparam int MIN_HIGH   = 8;
    localparam int MAX_HIGH   = 56;
    localparam int RESET_LOW  = RESET_TIME;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for pad inputs. Both flops reset asynchronously to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ws2812_rx_decoder.sv
// WS2812 single-wire receiver. It measures high and low times on the synchronized line and recovers
// 24-bit pixels, frame boundaries and framing errors.
module ws2812_rx_decoder #(
    parameter int BIT_THRESH = ws2812_pkg::BIT_THRESH,
    parameter int MIN_HIGH   = ws2812_pkg::MIN_HIGH,
    parameter int MAX_HIGH   = ws2812_pkg::MAX_HIGH,
    parameter int RESET_LOW  = ws2812_pkg::RESET_LOW
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic        frame_done,
    output logic [15:0] frame_pixels,
    output logic        bit_err,
    output logic        frame_err,
    output logic        err_sticky
);

    typedef ws2812_pkg::rx_state_t state_t;
    localparam state_t S_SYNC = ws2812_pkg::ST_SYNC;
    localparam state_t S_IDLE = ws2812_pkg::ST_IDLE;
    localparam state_t S_HIGH = ws2812_pkg::ST_HIGH;
    localparam state_t S_LOW  = ws2812_pkg::ST_LOW;

    localparam logic [5:0]  THRESH_C = 6'(BIT_THRESH);
    localparam logic [5:0]  MIN_C    = 6'(MIN_HIGH);
    localparam logic [5:0]  MAX_C    = 6'(MAX_HIGH);
    localparam logic [11:0] GAP_C    = 12'(RESET_LOW);
    localparam logic [11:0] GAP_M1_C = 12'(RESET_LOW - 1);

    function automatic logic [5:0] sat_inc6(input logic [5:0] v);
        return (v == 6'h3F) ? v : v + 6'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic        din_s;
    logic        din_d;
    logic        rise;
    logic        gap_reached;
    state_t      state_q;
    state_t      state_d;
    logic [5:0]  high_cnt;
    logic [11:0] low_cnt;
    logic [4:0]  bit_cnt;
    logic [15:0] pix_cnt;
    logic [22:0] shift_q;
    logic [23:0] shift_nx;
    logic        ev_bit_err;
    logic        ev_bit_done;
    logic        ev_pixel;
    logic        ev_frame_end;
    logic        ev_frame_err;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (din),
        .q     (din_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) din_d <= 1'b0;
        else        din_d <= din_s;
    end

    assign rise        = din_s & ~din_d;
    // Set on the low cycle that brings the consecutive-low count up to RESET_LOW.
    assign gap_reached = ~din_s & (low_cnt >= GAP_M1_C);
    assign shift_nx    = {shift_q, (high_cnt >= THRESH_C)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_SYNC;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_SYNC:  if (gap_reached) state_d = S_IDLE;
            S_IDLE:  if (rise) state_d = S_HIGH;
            S_HIGH: begin
                if (ev_bit_err)       state_d = S_SYNC;
                else if (ev_bit_done) state_d = S_LOW;
            end
            S_LOW: begin
                if (din_s)            state_d = S_HIGH;
                else if (gap_reached) state_d = S_IDLE;
            end
            default: state_d = S_SYNC;
        endcase
    end

    // In HIGH a low din_s is always the falling edge, because HIGH is only entered on a rise.
    always_comb begin
        ev_bit_err   = 1'b0;
        ev_bit_done  = 1'b0;
        ev_pixel     = 1'b0;
        ev_frame_end = 1'b0;
        ev_frame_err = 1'b0;
        case (state_q)
            S_HIGH: begin
                if (din_s) begin
                    ev_bit_err = (high_cnt >= MAX_C);
                end else if (high_cnt < MIN_C) begin
                    ev_bit_err = 1'b1;
                end else begin
                    ev_bit_done = 1'b1;
                    ev_pixel    = (bit_cnt == 5'd23);
                end
            end
            S_LOW: begin
                ev_frame_end = gap_reached;
                ev_frame_err = gap_reached && (bit_cnt != 5'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_cnt <= '0;
            low_cnt  <= '0;
            bit_cnt  <= '0;
            pix_cnt  <= '0;
            shift_q  <= '0;
        end else begin
            case (state_q)
                S_SYNC: begin
                    bit_cnt <= '0;
                    pix_cnt <= '0;
                    shift_q <= '0;
                    if (din_s)            low_cnt <= '0;
                    else if (gap_reached) low_cnt <= GAP_C;
                    else                  low_cnt <= low_cnt + 12'd1;
                end
                S_IDLE: begin
                    bit_cnt <= '0;
                    pix_cnt <= '0;
                    if (rise) high_cnt <= 6'd1;
                end
                S_HIGH: begin
                    if (din_s) high_cnt <= sat_inc6(high_cnt);
                    if (ev_bit_err) begin
                        bit_cnt <= '0;
                        pix_cnt <= '0;
                        shift_q <= '0;
                        low_cnt <= '0;
                    end else if (ev_bit_done) begin
                        low_cnt <= 12'd1;
                        if (ev_pixel) begin
                            shift_q <= '0;
                            bit_cnt <= '0;
                            pix_cnt <= sat_inc16(pix_cnt);
                        end else begin
                            shift_q <= shift_nx[22:0];
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                S_LOW: begin
                    if (din_s) begin
                        high_cnt <= 6'd1;
                    end else if (gap_reached) begin
                        low_cnt <= GAP_C;
                        bit_cnt <= '0;
                        pix_cnt <= '0;
                        shift_q <= '0;
                    end else begin
                        low_cnt <= low_cnt + 12'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_data   <= '0;
            pixel_valid  <= 1'b0;
            frame_done   <= 1'b0;
            frame_pixels <= '0;
            bit_err      <= 1'b0;
            frame_err    <= 1'b0;
            err_sticky   <= 1'b0;
        end else begin
            pixel_valid <= ev_pixel;
            frame_done  <= ev_frame_end;
            bit_err     <= ev_bit_err;
            frame_err   <= ev_frame_err;
            if (ev_pixel)                    pixel_data   <= shift_nx;
            if (ev_frame_end)                frame_pixels <= pix_cnt;
            if (ev_bit_err || ev_frame_err)  err_sticky   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Bench for ws2812_rx_decoder. It drives high/low line segments and predicts pixels, frames and
// bit errors from a segment-level model of the line protocol.
module tb_ws2812_rx_decoder;
    import ws2812_pkg::*;

    localparam int HALF = 500_000_000 / CLK_HZ;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        frame_done;
    logic [15:0] frame_pixels;
    logic        bit_err;
    logic        frame_err;
    logic        err_sticky;

    int vectors = 0;
    int miscompares = 0;

    logic [23:0] got_pix[$];
    logic [16:0] got_frm[$];
    int          got_berr = 0;
    int          got_bad = 0;

    logic [23:0] exp_pix[$];
    logic [16:0] exp_frm[$];
    int          exp_berr = 0;

    bit          m_synced;
    int          m_nbits;
    int          m_npix;
    logic [23:0] m_word;
    logic [23:0] m_last_pix;

    ws2812_rx_decoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din),
        .pixel_data   (pixel_data),
        .pixel_valid  (pixel_valid),
        .frame_done   (frame_done),
        .frame_pixels (frame_pixels),
        .bit_err      (bit_err),
        .frame_err    (frame_err),
        .err_sticky   (err_sticky)
    );

    always #HALF clk = ~clk;

    always @(negedge clk) begin
        if (pixel_valid) got_pix.push_back(pixel_data);
        if (frame_done)  got_frm.push_back({frame_err, frame_pixels});
        if (bit_err)     got_berr++;
        if ((frame_err && !frame_done) || (pixel_valid && bit_err)) got_bad++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        m_synced   = 1'b0;
        m_nbits    = 0;
        m_npix     = 0;
        m_word     = '0;
        m_last_pix = '0;
    endtask

    // One segment = h cycles high followed by l cycles low, judged by the line-protocol rules.
    task automatic model_seg(input int h, input int l);
        if (h == 0 || !m_synced) begin
            if (l >= RESET_LOW) m_synced = 1'b1;
            return;
        end
        if (h < MIN_HIGH || h > MAX_HIGH) begin
            exp_berr++;
            m_nbits  = 0;
            m_npix   = 0;
            m_synced = (l >= RESET_LOW);
            return;
        end
        m_word = {m_word[22:0], (h >= BIT_THRESH)};
        m_nbits++;
        if (m_nbits == 24) begin
            exp_pix.push_back(m_word);
            m_last_pix = m_word;
            m_npix++;
            m_nbits = 0;
        end
        if (l >= RESET_LOW) begin
            exp_frm.push_back({(m_nbits != 0), 16'(m_npix)});
            m_npix  = 0;
            m_nbits = 0;
        end
    endtask

    task automatic send_seg(input int h, input int l);
        model_seg(h, l);
        if (h > 0) begin
            din = 1'b1;
            tick(h);
        end
        din = 1'b0;
        tick(l);
    endtask

    task automatic send_word(input logic [23:0] w, input int tail);
        for (int i = 23; i >= 0; i--) begin
            int h = w[i] ? T1H : T0H;
            int l = TOTAL - h;
            if (i == 0 && tail > 0) l = tail;
            send_seg(h, l);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        din   = 1'b0;
        model_reset();
        tick(3);
        vectors++;
        if ({pixel_data, pixel_valid, frame_done, frame_pixels, bit_err, frame_err, err_sticky} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h/%b/%b/%h/%b/%b/%b expected all zero", pixel_data,
                     pixel_valid, frame_done, frame_pixels, bit_err, frame_err, err_sticky);
        end
        rst_n = 1'b1;
        send_seg(0, 2600);
        vectors++;
        if (got_pix.size() != 0 || got_frm.size() != 0 || got_berr != 0 || err_sticky !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_sync_quiet: got pix=%0d frm=%0d berr=%0d sticky=%b expected none",
                     got_pix.size(), got_frm.size(), got_berr, err_sticky);
        end
    endtask

    task automatic test_single_pixel();
        int bp = got_pix.size();
        int bf = got_frm.size();
        int bb = got_berr;
        send_word(24'h00FF00, 2600);
        vectors++;
        if (got_pix.size() - bp != 1 || got_pix[got_pix.size() - 1] !== 24'h00FF00) begin
            miscompares++;
            $display("FAIL single_pixel: got %0d pixels last=%h expected 1 pixel 00ff00",
                     got_pix.size() - bp, pixel_data);
        end
        vectors++;
        if (got_frm.size() - bf != 1 || got_frm[got_frm.size() - 1] !== {1'b0, 16'd1}) begin
            miscompares++;
            $display("FAIL single_frame: got %0d frames last=%h expected 1 frame 00001",
                     got_frm.size() - bf, {frame_err, frame_pixels});
        end
        vectors++;
        if (got_berr != bb || err_sticky !== 1'b0) begin
            miscompares++;
            $display("FAIL single_no_err: got berr=%0d sticky=%b expected 0/0", got_berr - bb, err_sticky);
        end
    endtask

    task automatic test_back_to_back();
        int bp = got_pix.size();
        int ep = exp_pix.size();
        int bf = got_frm.size();
        int ef = exp_frm.size();
        send_word(24'h123456, 0);
        send_word(24'hABCDEF, 2600);
        vectors++;
        if (got_pix.size() - bp != exp_pix.size() - ep) begin
            miscompares++;
            $display("FAIL b2b_pixel_count: got %0d expected %0d", got_pix.size() - bp, exp_pix.size() - ep);
        end else begin
            for (int i = 0; i < exp_pix.size() - ep; i++) begin
                vectors++;
                if (got_pix[bp + i] !== exp_pix[ep + i]) begin
                    miscompares++;
                    $display("FAIL b2b_pixel[%0d]: got %h expected %h", i, got_pix[bp + i], exp_pix[ep + i]);
                end
            end
        end
        vectors++;
        if (got_frm.size() - bf != 1 || got_frm[bf] !== exp_frm[ef]) begin
            miscompares++;
            $display("FAIL b2b_frame: got %0d frames pixels=%0d expected 1 frame pixels=%0d",
                     got_frm.size() - bf, frame_pixels, exp_frm[ef][15:0]);
        end
    endtask

    task automatic test_threshold();
        int bp = got_pix.size();
        int ep = exp_pix.size();
        int bf = got_frm.size();
        int ef = exp_frm.size();
        int bb = got_berr;
        int eb = exp_berr;
        // High times 8/31/30/56 probe both legal limits and both sides of the bit threshold.
        for (int i = 0; i < 24; i++) begin
            int h;
            case (i % 4)
                0:       h = 8;
                1:       h = 31;
                2:       h = 30;
                default: h = 56;
            endcase
            send_seg(h, (i == 23) ? 2600 : 20);
        end
        for (int i = 0; i < 5; i++) send_seg(T1H, 22);
        send_seg(7, 22);
        for (int i = 0; i < 30; i++) send_seg(T1H, (i == 29) ? 2600 : 22);
        send_word(24'hA5A5A5, 2600);
        vectors++;
        if (got_pix.size() - bp != exp_pix.size() - ep) begin
            miscompares++;
            $display("FAIL thr_pixel_count: got %0d expected %0d", got_pix.size() - bp, exp_pix.size() - ep);
        end else begin
            for (int i = 0; i < exp_pix.size() - ep; i++) begin
                vectors++;
                if (got_pix[bp + i] !== exp_pix[ep + i]) begin
                    miscompares++;
                    $display("FAIL thr_pixel[%0d]: got %h expected %h", i, got_pix[bp + i], exp_pix[ep + i]);
                end
            end
        end
        vectors++;
        if (got_frm.size() - bf != exp_frm.size() - ef) begin
            miscompares++;
            $display("FAIL thr_frame_count: got %0d expected %0d", got_frm.size() - bf, exp_frm.size() - ef);
        end
        vectors++;
        if (got_berr - bb != exp_berr - eb || err_sticky !== 1'b1) begin
            miscompares++;
            $display("FAIL thr_glitch_err: got berr=%0d sticky=%b expected berr=%0d sticky=1",
                     got_berr - bb, err_sticky, exp_berr - eb);
        end
    endtask

    task automatic test_stuck_high();
        int bp = got_pix.size();
        int bf = got_frm.size();
        int bb = got_berr;
        int eb = exp_berr;
        send_seg(57, 2600);
        send_seg(70, 2600);
        vectors++;
        if (got_berr - bb != exp_berr - eb) begin
            miscompares++;
            $display("FAIL stuck_bit_err: got %0d pulses expected %0d", got_berr - bb, exp_berr - eb);
        end
        vectors++;
        if (got_pix.size() != bp || got_frm.size() != bf) begin
            miscompares++;
            $display("FAIL stuck_no_data: got pix=%0d frm=%0d expected 0/0", got_pix.size() - bp,
                     got_frm.size() - bf);
        end
    endtask

    task automatic test_partial_frame();
        int bp = got_pix.size();
        int bf = got_frm.size();
        int ef = exp_frm.size();
        logic [23:0] w = 24'($urandom);
        for (int i = 0; i < 10; i++) send_seg(w[i] ? T1H : T0H, (i == 9) ? 2600 : 30);
        vectors++;
        if (got_frm.size() - bf != 1 || got_frm[bf] !== exp_frm[ef]) begin
            miscompares++;
            $display("FAIL partial_frame: got %0d frames err/pixels=%h expected 1 frame %h",
                     got_frm.size() - bf, {frame_err, frame_pixels}, exp_frm[ef]);
        end
        vectors++;
        if (got_pix.size() != bp || pixel_data !== m_last_pix) begin
            miscompares++;
            $display("FAIL partial_pixel_kept: got %h (%0d new) expected %h", pixel_data,
                     got_pix.size() - bp, m_last_pix);
        end
    endtask

    task automatic test_reset_mid();
        int bp;
        int ep;
        int bf;
        int ef;
        for (int i = 0; i < 12; i++) send_seg(T1H, 22);
        din = 1'b1;
        tick(5);
        #4 rst_n = 1'b0;
        #1;
        vectors++;
        if ({pixel_data, pixel_valid, frame_done, frame_pixels, bit_err, frame_err, err_sticky} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got %h/%b/%b/%h/%b/%b/%b expected all zero", pixel_data,
                     pixel_valid, frame_done, frame_pixels, bit_err, frame_err, err_sticky);
        end
        model_reset();
        din = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(10);
        bp = got_pix.size();
        ep = exp_pix.size();
        bf = got_frm.size();
        ef = exp_frm.size();
        send_word(24'h5A5A5A, 2600);
        send_word(24'hC0FFEE, 2600);
        vectors++;
        if (got_pix.size() - bp != 1 || exp_pix.size() - ep != 1 || got_pix[bp] !== exp_pix[ep]) begin
            miscompares++;
            $display("FAIL midreset_resync: got %0d pixels last=%h expected 1 pixel %h",
                     got_pix.size() - bp, pixel_data, 24'hC0FFEE);
        end
        vectors++;
        if (got_frm.size() - bf != 1 || got_frm[bf] !== exp_frm[ef]) begin
            miscompares++;
            $display("FAIL midreset_frame: got %0d frames pixels=%0d expected 1 frame pixels=1",
                     got_frm.size() - bf, frame_pixels);
        end
    endtask

    task automatic test_random();
        int bp = got_pix.size();
        int ep = exp_pix.size();
        int bf = got_frm.size();
        int ef = exp_frm.size();
        int bb = got_berr;
        int eb = exp_berr;
        for (int f = 0; f < 4; f++) begin
            int npix = $urandom_range(1, 2);
            int variant = $urandom_range(0, 3);
            for (int p = 0; p < npix; p++) begin
                for (int b = 0; b < 24; b++) begin
                    int l = $urandom_range(2, 40);
                    if (p == npix - 1 && b == 23 && variant >= 2) l = 2600;
                    send_seg($urandom_range(MIN_HIGH, MAX_HIGH), l);
                end
            end
            if (variant == 0) begin
                int k = $urandom_range(1, 23);
                for (int b = 0; b < k; b++)
                    send_seg($urandom_range(MIN_HIGH, MAX_HIGH), (b == k - 1) ? 2600 : $urandom_range(2, 40));
            end else if (variant == 1) begin
                send_seg($urandom_range(0, 1) ? $urandom_range(1, MIN_HIGH - 1) : $urandom_range(MAX_HIGH + 1, 75), 2600);
            end
        end
        vectors++;
        if (got_pix.size() - bp != exp_pix.size() - ep) begin
            miscompares++;
            $display("FAIL rand_pixel_count: got %0d expected %0d", got_pix.size() - bp, exp_pix.size() - ep);
        end else begin
            for (int i = 0; i < exp_pix.size() - ep; i++) begin
                vectors++;
                if (got_pix[bp + i] !== exp_pix[ep + i]) begin
                    miscompares++;
                    $display("FAIL rand_pixel[%0d]: got %h expected %h", i, got_pix[bp + i], exp_pix[ep + i]);
                end
            end
        end
        vectors++;
        if (got_frm.size() - bf != exp_frm.size() - ef) begin
            miscompares++;
            $display("FAIL rand_frame_count: got %0d expected %0d", got_frm.size() - bf, exp_frm.size() - ef);
        end else begin
            for (int i = 0; i < exp_frm.size() - ef; i++) begin
                vectors++;
                if (got_frm[bf + i] !== exp_frm[ef + i]) begin
                    miscompares++;
                    $display("FAIL rand_frame[%0d]: got %h expected %h", i, got_frm[bf + i], exp_frm[ef + i]);
                end
            end
        end
        vectors++;
        if (got_berr - bb != exp_berr - eb) begin
            miscompares++;
            $display("FAIL rand_bit_err: got %0d expected %0d", got_berr - bb, exp_berr - eb);
        end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_back_to_back();
        test_threshold();
        test_stuck_high();
        test_partial_frame();
        test_reset_mid();
        test_random();
        tick(4);
        vectors++;
        if (got_bad != 0) begin
            miscompares++;
            $display("FAIL pulse_coincidence: got %0d illegal cycles expected 0", got_bad);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
